// File: rtl/shot_sequencer.sv
// Per-shot acquisition controller: arm, trigger, delay, gated IQ window, drain.
// Optional watchdog in ACQ is built when SHOT_TIMEOUT_EN is defined.
module shot_sequencer #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk100,
   input  logic             reset,
   input  logic             arm,
   input  logic             abort,
   input  logic             trigger,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_window,
   input  logic [CNT_W-1:0] cfg_num_shots,
   input  logic             iq_valid,
   input  logic             analyze_done,
   output logic             acq_gate,
   output logic             shot_start,
   output logic             shot_end,
   output logic [CNT_W-1:0] shot_count,
   output logic             busy,
   output logic             run_done,
   output logic             err_overrun,
   output logic             err_timeout
);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DELAY,
      ACQ,
      DRAIN,
      DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic             trigger_d;
   logic             trig_edge;
   logic [CNT_W-1:0] delay_q;
   logic [CNT_W-1:0] window_q;
   logic [CNT_W-1:0] shots_q;
   logic [CNT_W-1:0] dly_cnt;
   logic [CNT_W-1:0] smp_cnt;
   logic [CNT_W-1:0] window_eff;
   logic [CNT_W-1:0] smp_inc;
   logic [CNT_W-1:0] shot_inc;
   logic             last_smp;
   logic             shot_fin;
   logic             timeout_hit;

   assign trig_edge  = trigger & ~trigger_d;
   assign window_eff = (window_q == '0) ? CNT_W'(1) : window_q;
   assign smp_inc    = (smp_cnt == '1) ? smp_cnt : smp_cnt + 1'b1;
   assign shot_inc   = (shot_count == '1) ? shot_count : shot_count + 1'b1;
   assign last_smp   = iq_valid && (smp_inc >= window_eff);

`ifdef SHOT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] idle_cnt;

   assign timeout_hit = (state == ACQ) && !iq_valid &&
                        (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         idle_cnt    <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state != ACQ || iq_valid)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + 1'b1;
         if (state == IDLE && arm && !abort)
            err_timeout <= 1'b0;
         else if (timeout_hit && !abort)
            err_timeout <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      shot_end = 1'b0;
      shot_fin = 1'b0;
      unique case (state)
         IDLE: begin
            if (arm)
               state_nx = ARMED;
         end
         ARMED: begin
            if (shots_q == '0)
               state_nx = DONE;
            else if (trig_edge)
               state_nx = (delay_q == '0) ? ACQ : DELAY;
         end
         DELAY: begin
            if (dly_cnt <= CNT_W'(1))
               state_nx = ACQ;
         end
         ACQ: begin
            if (last_smp) begin
               shot_end = 1'b1;
               if (analyze_done) begin
                  shot_fin = 1'b1;
                  state_nx = (shot_inc == shots_q) ? DONE : ARMED;
               end else begin
                  state_nx = DRAIN;
               end
            end else if (timeout_hit) begin
               state_nx = IDLE;
            end
         end
         DRAIN: begin
            if (analyze_done) begin
               shot_fin = 1'b1;
               state_nx = (shot_inc == shots_q) ? DONE : ARMED;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      // abort outranks every other event, including a completing shot
      if (abort) begin
         state_nx = IDLE;
         shot_end = 1'b0;
         shot_fin = 1'b0;
      end
   end

   assign busy     = (state != IDLE);
   assign run_done = (state == DONE) && !abort;

   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         trigger_d   <= 1'b0;
         delay_q     <= '0;
         window_q    <= '0;
         shots_q     <= '0;
         dly_cnt     <= '0;
         smp_cnt     <= '0;
         shot_count  <= '0;
         acq_gate    <= 1'b0;
         shot_start  <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state      <= state_nx;
         trigger_d  <= trigger;
         acq_gate   <= (state_nx == ACQ);
         shot_start <= (state_nx == ACQ) && (state != ACQ);

         if (state == IDLE && arm && !abort) begin
            delay_q     <= cfg_delay;
            window_q    <= cfg_window;
            shots_q     <= cfg_num_shots;
            shot_count  <= '0;
            err_overrun <= 1'b0;
         end

         if (state == ARMED && trig_edge && !abort)
            dly_cnt <= delay_q;
         else if (state == DELAY && dly_cnt != '0)
            dly_cnt <= dly_cnt - 1'b1;

         if (state != ACQ)
            smp_cnt <= '0;
         else if (iq_valid)
            smp_cnt <= smp_inc;

         if (shot_fin)
            shot_count <= shot_inc;

         // late triggers are flagged but never queued
         if (trig_edge && !abort &&
             (state == DELAY || state == ACQ || state == DRAIN))
            err_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed bench for shot_sequencer: one task per scenario, inline checks.
module tb_shot_sequencer;

   localparam int CW = 16;

   logic          clk100 = 1'b0;
   logic          reset;
   logic          arm;
   logic          abort;
   logic          trigger;
   logic [CW-1:0] cfg_delay;
   logic [CW-1:0] cfg_window;
   logic [CW-1:0] cfg_num_shots;
   logic          iq_valid;
   logic          analyze_done;
   logic          acq_gate;
   logic          shot_start;
   logic          shot_end;
   logic [CW-1:0] shot_count;
   logic          busy;
   logic          run_done;
   logic          err_overrun;
   logic          err_timeout;

   int vecs = 0;
   int errs = 0;

   int n_gate, first_gate, n_start, n_end, first_end, n_done, done_idx;

   shot_sequencer #(
      .CNT_W(CW),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk100(clk100),
      .reset(reset),
      .arm(arm),
      .abort(abort),
      .trigger(trigger),
      .cfg_delay(cfg_delay),
      .cfg_window(cfg_window),
      .cfg_num_shots(cfg_num_shots),
      .iq_valid(iq_valid),
      .analyze_done(analyze_done),
      .acq_gate(acq_gate),
      .shot_start(shot_start),
      .shot_end(shot_end),
      .shot_count(shot_count),
      .busy(busy),
      .run_done(run_done),
      .err_overrun(err_overrun),
      .err_timeout(err_timeout)
   );

   always #5 clk100 = ~clk100;

   task automatic clr_obs();
      n_gate = 0; first_gate = -1; n_start = 0;
      n_end = 0; first_end = -1; n_done = 0; done_idx = -1;
   endtask

   task automatic observe(input int c);
      if (acq_gate) begin
         n_gate++;
         if (first_gate < 0) first_gate = c;
      end
      if (shot_start) n_start++;
      if (shot_end) begin
         n_end++;
         if (first_end < 0) first_end = c;
      end
      if (run_done) begin
         n_done++;
         done_idx = c;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; arm = 0; abort = 0; trigger = 0;
      iq_valid = 0; analyze_done = 0;
      cfg_delay = '0; cfg_window = '0; cfg_num_shots = '0;
      repeat (2) @(posedge clk100);
      #1 reset = 1'b0;
      clr_obs();
   endtask

   task automatic test_reset();
      reset = 1'b1; arm = 0; abort = 0; trigger = 0;
      iq_valid = 0; analyze_done = 0;
      cfg_delay = '0; cfg_window = '0; cfg_num_shots = '0;
      @(negedge clk100);
      vecs++;
      if ({acq_gate, shot_start, shot_end, busy, run_done,
           err_overrun, err_timeout, shot_count} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: got gate=%b busy=%b cnt=%0d, want all 0",
                  acq_gate, busy, shot_count);
      end
      @(posedge clk100); #1 reset = 1'b0;
      @(negedge clk100);
      vecs++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL reset_idle: busy=%b, want 0", busy);
      end
      @(posedge clk100); #1;
   endtask

   task automatic test_basic();
      do_reset();
      cfg_delay = 3; cfg_window = 4; cfg_num_shots = 2;
      for (int c = 0; c < 25; c++) begin
         arm = (c == 0);
         trigger = (c >= 1 && c <= 8) || (c >= 12);
         iq_valid = 1'b1;
         analyze_done = (c == 10) || (c == 20);
         @(negedge clk100);
         observe(c);
         if (c == 11) begin
            vecs++;
            if (shot_count !== 16'd1) begin
               errs++;
               $display("FAIL basic_count1: got %0d, want 1", shot_count);
            end
         end
         @(posedge clk100); #1;
      end
      arm = 0; trigger = 0; iq_valid = 0; analyze_done = 0;
      vecs++;
      if (first_gate !== 5) begin
         errs++; $display("FAIL basic_gate_open: cycle %0d, want 5", first_gate);
      end
      vecs++;
      if (n_gate !== 8) begin
         errs++; $display("FAIL basic_gate_len: %0d cycles, want 8", n_gate);
      end
      vecs++;
      if (n_start !== 2 || n_end !== 2) begin
         errs++;
         $display("FAIL basic_pulses: start=%0d end=%0d, want 2/2", n_start, n_end);
      end
      vecs++;
      if (first_end !== 8) begin
         errs++; $display("FAIL basic_end_cycle: %0d, want 8", first_end);
      end
      vecs++;
      if (n_done !== 1 || done_idx !== 21) begin
         errs++;
         $display("FAIL basic_run_done: n=%0d at %0d, want 1 at 21", n_done, done_idx);
      end
      vecs++;
      if (shot_count !== 16'd2 || busy !== 1'b0 || err_overrun !== 1'b0) begin
         errs++;
         $display("FAIL basic_final: cnt=%0d busy=%b ovr=%b, want 2/0/0",
                  shot_count, busy, err_overrun);
      end
   endtask

   task automatic test_zero_delay_window();
      do_reset();
      cfg_delay = 0; cfg_window = 0; cfg_num_shots = 1;
      for (int c = 0; c < 8; c++) begin
         arm = (c == 0);
         trigger = (c >= 1);
         iq_valid = (c >= 2);
         analyze_done = (c == 2);
         @(negedge clk100);
         observe(c);
         @(posedge clk100); #1;
      end
      arm = 0; trigger = 0; iq_valid = 0; analyze_done = 0;
      vecs++;
      if (first_gate !== 2 || n_gate !== 1) begin
         errs++;
         $display("FAIL zero_gate: open %0d len %0d, want 2/1", first_gate, n_gate);
      end
      vecs++;
      if (n_end !== 1 || first_end !== 2) begin
         errs++;
         $display("FAIL zero_end: n=%0d at %0d, want 1 at 2", n_end, first_end);
      end
      vecs++;
      if (n_done !== 1 || done_idx !== 3) begin
         errs++;
         $display("FAIL zero_same_cycle_done: n=%0d at %0d, want 1 at 3",
                  n_done, done_idx);
      end
      vecs++;
      if (shot_count !== 16'd1) begin
         errs++; $display("FAIL zero_count: %0d, want 1", shot_count);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      cfg_delay = 1; cfg_window = 3; cfg_num_shots = 1;
      for (int c = 0; c < 15; c++) begin
         arm = (c == 0);
         trigger = (c >= 1 && c <= 2) || (c >= 4 && c <= 8) || (c >= 10);
         iq_valid = 1'b1;
         analyze_done = (c == 7);
         @(negedge clk100);
         observe(c);
         if (c == 4 || c == 5) begin
            vecs++;
            if (err_overrun !== (c == 5)) begin
               errs++;
               $display("FAIL overrun_flag_c%0d: got %b, want %b",
                        c, err_overrun, (c == 5));
            end
         end
         @(posedge clk100); #1;
      end
      arm = 0; iq_valid = 0; analyze_done = 0;
      vecs++;
      if (first_gate !== 3 || n_gate !== 3 || n_end !== 1) begin
         errs++;
         $display("FAIL overrun_shot: open %0d len %0d ends %0d, want 3/3/1",
                  first_gate, n_gate, n_end);
      end
      vecs++;
      if (n_done !== 1 || done_idx !== 8 || shot_count !== 16'd1) begin
         errs++;
         $display("FAIL overrun_done: n=%0d at %0d cnt=%0d, want 1 at 8 cnt 1",
                  n_done, done_idx, shot_count);
      end
      vecs++;
      if (err_overrun !== 1'b1 || busy !== 1'b0) begin
         errs++;
         $display("FAIL overrun_sticky: ovr=%b busy=%b, want 1/0", err_overrun, busy);
      end
   endtask

   // runs straight after test_overrun so the new arm must clear err_overrun
   task automatic test_abort();
      clr_obs();
      trigger = 0;
      cfg_delay = 0; cfg_window = 5; cfg_num_shots = 3;
      for (int c = 0; c < 14; c++) begin
         arm = (c == 0) || (c == 4);
         if (c >= 1) begin
            cfg_window = 1; cfg_num_shots = 1;
         end
         trigger = (c >= 1 && c <= 4) || (c >= 8);
         iq_valid = 1'b1;
         analyze_done = (c == 6);
         abort = (c == 10);
         @(negedge clk100);
         observe(c);
         if (c == 1) begin
            vecs++;
            if (err_overrun !== 1'b0) begin
               errs++; $display("FAIL abort_arm_clears_ovr: %b, want 0", err_overrun);
            end
         end
         if (c == 11) begin
            vecs++;
            if (acq_gate !== 1'b0 || busy !== 1'b0 || shot_count !== 16'd1) begin
               errs++;
               $display("FAIL abort_next: gate=%b busy=%b cnt=%0d, want 0/0/1",
                        acq_gate, busy, shot_count);
            end
         end
         @(posedge clk100); #1;
      end
      arm = 0; abort = 0; trigger = 0; iq_valid = 0; analyze_done = 0;
      vecs++;
      if (n_gate !== 7 || n_end !== 1 || first_end !== 6) begin
         errs++;
         $display("FAIL abort_shots: gate %0d ends %0d at %0d, want 7/1/6",
                  n_gate, n_end, first_end);
      end
      vecs++;
      if (n_done !== 0) begin
         errs++; $display("FAIL abort_no_done: %0d run_done, want 0", n_done);
      end
   endtask

   task automatic test_zero_shots();
      do_reset();
      cfg_delay = 0; cfg_window = 1; cfg_num_shots = 0;
      for (int c = 0; c < 7; c++) begin
         arm = (c == 0);
         trigger = (c >= 1);
         iq_valid = 1'b1;
         @(negedge clk100);
         observe(c);
         if (c == 1) begin
            vecs++;
            if (busy !== 1'b1) begin
               errs++; $display("FAIL zshot_busy: %b, want 1", busy);
            end
         end
         @(posedge clk100); #1;
      end
      arm = 0; trigger = 0; iq_valid = 0;
      vecs++;
      if (n_done !== 1 || done_idx !== 2) begin
         errs++;
         $display("FAIL zshot_done: n=%0d at %0d, want 1 at 2", n_done, done_idx);
      end
      vecs++;
      if (n_gate !== 0 || shot_count !== 16'd0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL zshot_final: gate %0d cnt %0d busy %b, want 0/0/0",
                  n_gate, shot_count, busy);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      cfg_delay = 0; cfg_window = 2; cfg_num_shots = 1;
      for (int c = 0; c < 41; c++) begin
         arm = (c == 0);
         trigger = (c >= 1);
         iq_valid = 1'b0;
         @(negedge clk100);
         observe(c);
`ifdef SHOT_TIMEOUT_EN
         if (c == 17) begin
            vecs++;
            if (acq_gate !== 1'b1 || err_timeout !== 1'b0) begin
               errs++;
               $display("FAIL tmo_before: gate=%b tmo=%b, want 1/0", acq_gate, err_timeout);
            end
         end
         if (c == 18) begin
            vecs++;
            if (err_timeout !== 1'b1 || busy !== 1'b0 || acq_gate !== 1'b0) begin
               errs++;
               $display("FAIL tmo_fire: tmo=%b busy=%b gate=%b, want 1/0/0",
                        err_timeout, busy, acq_gate);
            end
         end
`else
         if (c == 18 || c == 40) begin
            vecs++;
            if (busy !== 1'b1 || acq_gate !== 1'b1 || err_timeout !== 1'b0) begin
               errs++;
               $display("FAIL tmo_stay_c%0d: busy=%b gate=%b tmo=%b, want 1/1/0",
                        c, busy, acq_gate, err_timeout);
            end
         end
`endif
         @(posedge clk100); #1;
      end
      arm = 0;
      vecs++;
      if (n_done !== 0) begin
         errs++; $display("FAIL tmo_no_done: %0d, want 0", n_done);
      end
   endtask

   task automatic test_reset_midrun();
      do_reset();
      cfg_delay = 0; cfg_window = 8; cfg_num_shots = 2;
      arm = 1'b1;
      @(posedge clk100); #1 arm = 1'b0; trigger = 1'b1; iq_valid = 1'b1;
      @(posedge clk100); #1;
      @(posedge clk100); #3;
      vecs++;
      if (acq_gate !== 1'b1) begin
         errs++; $display("FAIL midrun_setup: gate=%b, want 1", acq_gate);
      end
      reset = 1'b1;
      #1;
      vecs++;
      if ({acq_gate, shot_start, shot_end, busy, run_done,
           err_overrun, err_timeout, shot_count} !== '0) begin
         errs++;
         $display("FAIL midrun_reset: gate=%b busy=%b, want 0/0", acq_gate, busy);
      end
      @(posedge clk100); #1 reset = 1'b0; trigger = 0; iq_valid = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_delay_window();
      test_overrun();
      test_abort();
      test_zero_shots();
      test_timeout();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
